// File: rtl/page_reg_file.sv
// Eight-entry flop-based register file with a registered read port and write-through bypass.
// Optional scan chain over all entries is compiled in with PAGE_REG_FILE_SCAN_EN.
module page_reg_file #(
   parameter int                WIDTH   = 8,
   parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en_in,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] din,
   input  logic             en_out,
   input  logic [2:0]       rd_addr,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic             tc,
   input  logic             td,
   output logic             tq
);

   localparam int DEPTH = 8;
   localparam int CHAIN = DEPTH * WIDTH;

   logic [DEPTH-1:0][WIDTH-1:0] r_mem;
   logic                        w_wr;
   logic                        w_rd;
   logic [WIDTH-1:0]            w_rd_data;

`ifdef PAGE_REG_FILE_SCAN_EN
   logic [CHAIN-1:0] w_chain;
   logic [CHAIN-1:0] w_chain_nxt;

   // Entry 0 bit 0 sits at the LSB of the flattened array, so a left shift walks the chain.
   assign w_chain     = r_mem;
   assign w_chain_nxt = {w_chain[CHAIN-2:0], td};
   assign w_wr        = en_in  & ~tc;
   assign w_rd        = en_out & ~tc;
   assign tq          = r_mem[DEPTH-1][WIDTH-1];
`else
   logic w_unused_scan;

   assign w_unused_scan = tc ^ td;
   assign w_wr          = en_in;
   assign w_rd          = en_out;
   assign tq            = 1'b0;
`endif

   assign w_rd_data = (w_wr && (wr_addr == rd_addr)) ? din : r_mem[rd_addr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem <= {DEPTH{RST_VAL}};
      end
`ifdef PAGE_REG_FILE_SCAN_EN
      else if (tc) begin
         r_mem <= w_chain_nxt;
      end
`endif
      else if (w_wr) begin
         r_mem[wr_addr] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout     <= {WIDTH{1'b0}};
         dout_vld <= 1'b0;
      end else if (w_rd) begin
         dout     <= w_rd_data;
         dout_vld <= 1'b1;
      end else begin
         dout_vld <= 1'b0;
      end
   end

endmodule

// File: doc/page_reg_file.md
PAGE_REG_FILE -- requirements
Module: page_reg_file

Interface
REQ-001 Parameter: WIDTH, 8, data width of each entry and of din/dout.
REQ-002 Parameter: RST_VAL, {WIDTH{1'b0}}, value loaded into every entry at reset.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: en_in  input  1  write enable.
REQ-006 Port: wr_addr  input  3  write entry index (0..7).
REQ-007 Port: din  input  WIDTH  write data.
REQ-008 Port: en_out  input  1  read request.
REQ-009 Port: rd_addr  input  3  read entry index (0..7).
REQ-010 Port: dout  output  WIDTH  registered read data.
REQ-011 Port: dout_vld  output  1  dout holds data for a read accepted last cycle.
REQ-012 Port: tc  input  1  scan shift enable.
REQ-013 Port: td  input  1  scan serial in.
REQ-014 Port: tq  output  1  scan serial out.

Function
REQ-015 Storage: 8 entries x WIDTH bits, flops only, no memory macro.
REQ-016 Write: en_in=1 and tc=0 at posedge -> entry[wr_addr] <= din; other entries hold.
REQ-017 Read: en_out=1 and tc=0 at posedge -> dout <= entry[rd_addr], dout_vld <= 1; latency exactly 1 cycle.
REQ-018 No read accepted -> dout holds previous value, dout_vld <= 0.
REQ-019 Write/read collision (en_in, en_out, wr_addr==rd_addr, same edge) -> dout <= din (write-through bypass).
REQ-020 Write and read to different addresses same edge -> read returns old content of rd_addr; write lands normally.
REQ-021 Back-to-back reads every cycle -> dout_vld stays 1, dout updates each cycle; no bubbles.
REQ-022 Address fields are full 3-bit; no out-of-range case, no wrap logic required.
REQ-023 Scan (macro defined, tc=1): chain of 8*WIDTH bits shifts one bit per cycle; td -> entry[0] bit 0 -> ... -> entry[0] bit WIDTH-1 -> entry[1] bit 0 -> ... -> entry[7] bit WIDTH-1.
REQ-024 tq = entry[7] bit WIDTH-1 directly from flop, no extra register.
REQ-025 tc=1 has priority: en_in and en_out ignored, dout holds, dout_vld <= 0.
REQ-026 tc falling: normal operation resumes next edge; no state beyond shifted contents is altered.

Reset
REQ-027 reset_n low -> immediately, independent of clk: all entries = RST_VAL, dout = 0, dout_vld = 0.
REQ-028 reset_n asserted mid-operation (write, read, or scan) -> pending operation discarded; no partial update survives.
REQ-029 reset_n deassertion: first functional edge is the first posedge clk with reset_n high; no internal synchroniser in this block.

Configuration
REQ-030 Macro PAGE_REG_FILE_SCAN_EN defined -> scan per REQ-023..REQ-026 compiled in.
REQ-031 PAGE_REG_FILE_SCAN_EN undefined -> tc, td ignored (ports kept), tq tied 1'b0, no scan muxing in datapath.

Verification
REQ-032 Reset then en_out=1, rd_addr=5 -> next cycle dout=8'h00, dout_vld=1 (RST_VAL default).
REQ-033 Write 8'hA5 to 3, then read 3 next cycle -> dout=8'hA5 one cycle after read edge; entries 0-2,4-7 unchanged.
REQ-034 Same edge: en_in=1, wr_addr=2, din=8'h3C, en_out=1, rd_addr=2 -> dout=8'h3C; same case with rd_addr=6 -> dout=old entry[6].
REQ-035 Reads to 0..7 on 8 consecutive cycles after writing entry[i]=i*8'h11 -> dout_vld=1 continuously, dout sequence 00,11,...,77.
REQ-036 SCAN_EN defined: tc=1, td=1 for 64 cycles from reset -> tq rises on shift 64, all entries 8'hFF; en_in pulses during shift have no effect.
REQ-037 reset_n pulsed low between edges while entry[4]=8'h5A and dout_vld=1 -> dout_vld, dout and entry[4] read 0 before next posedge.
